// File: rtl/palette_sequencer_pkg.sv
// Purpose : shared colour constants, the 8-entry base colour table and sizing helpers.
// Latency : n/a (constants and pure functions only).
// Backpressure: n/a.
package color_pkg;

  localparam int COLOR_W = 24;
  localparam int BASE_N  = 8;

  // Packed so BASE[0] is the rightmost entry: 0 FF0000 ... 7 FFFFFF.
  localparam logic [BASE_N-1:0][COLOR_W-1:0] BASE = {
    24'hFFFFFF, 24'hFF8000, 24'hFF00FF, 24'h00FFFF,
    24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000
  };

  // Colour of player i in palette p. Truncating to 3 bits is the mod-8 wrap
  // into the base table.
  function automatic logic [COLOR_W-1:0] base_color(input int p, input int i, input int stride);
    logic [2:0] sel;
    sel = 3'(p + i * stride);
    return BASE[sel];
  endfunction

  // Palette index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/palette_sequencer_if.sv
// Purpose : control inputs and colour outputs of the palette sequencer as one bundle.
// Latency : n/a (wires only).
// Backpressure: none; colour outputs are always valid.
// master: drives toggle_color, step_back, auto_en, flash; reads color_out, palette_idx, wrap.
// slave : the sequencer itself.
interface palette_sequencer_if #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_PALETTES = 4
);
  import color_pkg::*;

  localparam int IDX_W = idx_width(NUM_PALETTES);

  logic                           toggle_color;
  logic                           step_back;
  logic                           auto_en;
  logic [NUM_PLAYERS-1:0]         flash;
  logic [NUM_PLAYERS*COLOR_W-1:0] color_out;
  logic [IDX_W-1:0]               palette_idx;
  logic                           wrap;

  modport master (
    output toggle_color, step_back, auto_en, flash,
    input  color_out, palette_idx, wrap
  );

  modport slave (
    input  toggle_color, step_back, auto_en, flash,
    output color_out, palette_idx, wrap
  );

endinterface

// File: rtl/palette_sequencer_btn.sv
// Purpose : 2-FF synchroniser plus rising-edge pulse for an asynchronous button level.
// Latency : rise is high in the cycle after the second sync flop captures the high level.
// Backpressure: none; a held level yields exactly one rise pulse.
// Ports: clk, reset (async active-high), btn_in (async level), rise (one-cycle pulse).
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/palette_sequencer.sv
// Purpose : palette index stepping (buttons / auto timer), per-player flash and registered colour out.
// Latency : button to index 2 edges after sync capture, colour 1 edge after index; flash 1 edge.
// Backpressure: none; colour outputs are valid every cycle from reset onward.
// Ports: clk, reset (async active-high), bus (slave side of palette_sequencer_if).
module palette_sequencer
  import color_pkg::*;
#(
  parameter int                 NUM_PLAYERS   = 2,
  parameter int                 NUM_PALETTES  = 4,
  parameter int                 PLAYER_STRIDE = 2,
  parameter int                 AUTO_PERIOD   = 25_000_000,
  parameter int                 FLASH_LEN     = 12_500_000,
  parameter logic [COLOR_W-1:0] FLASH_COLOR   = 24'hFFFFFF
) (
  input logic                clk,
  input logic                reset,
  palette_sequencer_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PALETTES);
  localparam int CNT_W = $clog2(AUTO_PERIOD);
  localparam int FL_W  = $clog2(FLASH_LEN + 1);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_PALETTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(FLASH_LEN);

  logic tog_rise;
  logic back_rise;

  btn_sync_edge u_tog (
    .clk    (clk),
    .reset  (reset),
    .btn_in (bus.toggle_color),
    .rise   (tog_rise)
  );

  btn_sync_edge u_back (
    .clk    (clk),
    .reset  (reset),
    .btn_in (bus.step_back),
    .rise   (back_rise)
  );

  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             auto_tick;
  logic             fwd_req;
  logic             do_fwd;
  logic             do_back;
  logic             btn_step;

  // Forward requests (button or timer) merge into a single +1. Any forward
  // request against a back edge cancels to no step at all.
  always_comb begin
    auto_tick = bus.auto_en && (auto_cnt_q == CNT_MAX);
    fwd_req   = tog_rise | auto_tick;
    do_fwd    = fwd_req & ~back_rise;
    do_back   = back_rise & ~fwd_req;
    btn_step  = (do_fwd & tog_rise) | do_back;

    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (do_fwd) begin
      if (idx_q == IDX_MAX) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (do_back) begin
      if (idx_q == '0) begin
        idx_d  = IDX_MAX;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end

    // A manual step restarts the period so the next auto advance is a full
    // period after the user's action.
    if (!bus.auto_en || btn_step || auto_tick) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      wrap_q     <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      wrap_q     <= wrap_d;
      auto_cnt_q <= auto_cnt_d;
    end
  end

  logic [NUM_PLAYERS-1:0][COLOR_W-1:0] color_all;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;
    logic [COLOR_W-1:0] color_q, color_d;

    // Colour mux looks at the counter before this edge's update, so the flash
    // colour appears one edge after the pulse and lasts FLASH_LEN edges.
    always_comb begin
      flash_cnt_d = flash_cnt_q;
      if (bus.flash[i]) begin
        flash_cnt_d = FL_LOAD;
      end else if (flash_cnt_q != '0) begin
        flash_cnt_d = flash_cnt_q - 1'b1;
      end
      color_d = (flash_cnt_q != '0) ? FLASH_COLOR
                                    : base_color(int'(idx_q), i, PLAYER_STRIDE);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flash_cnt_q <= '0;
        color_q     <= base_color(0, i, PLAYER_STRIDE);
      end else begin
        flash_cnt_q <= flash_cnt_d;
        color_q     <= color_d;
      end
    end

    assign color_all[i] = color_q;
  end

  assign bus.color_out   = color_all;
  assign bus.palette_idx = idx_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_palette_sequencer.sv
// Purpose : directed self-checking bench for palette_sequencer (2 players, 4 palettes, period 8, flash 4).
// Latency : outputs sampled on falling edges, inputs driven on falling edges.
// Backpressure: n/a.
module tb_palette_sequencer;

  localparam logic [47:0] PAL0   = {24'h0000FF, 24'hFF0000};
  localparam logic [47:0] PAL1   = {24'hFFFF00, 24'h00FF00};
  localparam logic [47:0] FL_P0  = {24'h0000FF, 24'hFFFFFF};
  localparam logic [47:0] FL_P1  = {24'hFFFFFF, 24'hFF0000};

  logic clk;
  logic reset;
  int   total;
  int   bad;

  palette_sequencer_if #(.NUM_PLAYERS(2), .NUM_PALETTES(4)) bus ();

  palette_sequencer #(
    .NUM_PLAYERS   (2),
    .NUM_PALETTES  (4),
    .PLAYER_STRIDE (2),
    .AUTO_PERIOD   (8),
    .FLASH_LEN     (4),
    .FLASH_COLOR   (24'hFFFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle button pulse; returns just after the edge where the index updates.
  task automatic press(input logic fwd, input logic bwd);
    bus.toggle_color = fwd;
    bus.step_back    = bwd;
    cyc(1);
    bus.toggle_color = 1'b0;
    bus.step_back    = 1'b0;
    cyc(2);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    bus.toggle_color = 1'b0;
    bus.step_back    = 1'b0;
    bus.auto_en      = 1'b0;
    bus.flash        = '0;

    // Reset state
    cyc(2);
    chk("rst_color", bus.color_out, PAL0);
    chk("rst_idx", bus.palette_idx, 0);
    chk("rst_wrap", bus.wrap, 0);
    reset = 1'b0;
    cyc(2);
    chk("post_rst_color", bus.color_out, PAL0);
    chk("post_rst_idx", bus.palette_idx, 0);

    // Held toggle: one step, index at k+2, colour at k+3
    bus.toggle_color = 1'b1;
    cyc(1);
    chk("hold_idx_k", bus.palette_idx, 0);
    cyc(1);
    chk("hold_idx_k1", bus.palette_idx, 0);
    cyc(1);
    chk("hold_idx_k2", bus.palette_idx, 1);
    chk("hold_color_k2", bus.color_out, PAL0);
    chk("hold_wrap_k2", bus.wrap, 0);
    cyc(1);
    chk("hold_color_k3", bus.color_out, PAL1);
    cyc(17);
    chk("hold_idx_still", bus.palette_idx, 1);
    bus.toggle_color = 1'b0;
    cyc(4);
    chk("hold_idx_release", bus.palette_idx, 1);

    // Asynchronous reset returns the index to 0 immediately
    reset = 1'b1;
    #1;
    chk("rst2_idx", bus.palette_idx, 0);
    chk("rst2_color", bus.color_out, PAL0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Forward wrap and backward wrap
    press(1'b1, 1'b0);
    chk("fw1_idx", bus.palette_idx, 1);
    chk("fw1_wrap", bus.wrap, 0);
    press(1'b1, 1'b0);
    chk("fw2_idx", bus.palette_idx, 2);
    chk("fw2_wrap", bus.wrap, 0);
    press(1'b1, 1'b0);
    chk("fw3_idx", bus.palette_idx, 3);
    chk("fw3_wrap", bus.wrap, 0);
    press(1'b1, 1'b0);
    chk("fw4_idx", bus.palette_idx, 0);
    chk("fw4_wrap", bus.wrap, 1);
    cyc(1);
    chk("fw4_wrap_drop", bus.wrap, 0);
    press(1'b0, 1'b1);
    chk("bk_idx", bus.palette_idx, 3);
    chk("bk_wrap", bus.wrap, 1);

    // Simultaneous edges cancel
    press(1'b1, 1'b1);
    chk("both_idx", bus.palette_idx, 3);
    chk("both_wrap", bus.wrap, 0);
    cyc(3);
    chk("both_idx_later", bus.palette_idx, 3);

    // Auto advance: counter starts at 0, first tick lands 7 edges after enable
    bus.auto_en = 1'b1;
    cyc(7);                                   // after a+6
    chk("auto_pre1", bus.palette_idx, 3);
    cyc(1);                                   // a+7
    chk("auto_t1_idx", bus.palette_idx, 0);
    chk("auto_t1_wrap", bus.wrap, 1);
    cyc(7);                                   // a+14
    chk("auto_pre2", bus.palette_idx, 0);
    cyc(1);                                   // a+15
    chk("auto_t2_idx", bus.palette_idx, 1);
    cyc(5);                                   // a+20: button edge lands on the a+23 tick
    bus.toggle_color = 1'b1;
    cyc(1);
    bus.toggle_color = 1'b0;
    cyc(1);                                   // a+22
    chk("coll_pre", bus.palette_idx, 1);
    cyc(1);                                   // a+23
    chk("coll_idx", bus.palette_idx, 2);
    chk("coll_wrap", bus.wrap, 0);
    cyc(1);                                   // a+24: mid-period press, update at a+27
    bus.toggle_color = 1'b1;
    cyc(1);
    bus.toggle_color = 1'b0;
    cyc(2);                                   // a+27
    chk("mid_idx", bus.palette_idx, 3);
    cyc(7);                                   // a+34: timer restarted, no tick at a+31
    chk("restart_idx", bus.palette_idx, 3);
    chk("restart_wrap", bus.wrap, 0);
    cyc(1);                                   // a+35
    chk("restart_tick_idx", bus.palette_idx, 0);
    chk("restart_tick_wrap", bus.wrap, 1);
    bus.auto_en = 1'b0;
    cyc(2);
    chk("auto_off_color", bus.color_out, PAL0);

    // Flash player 0, re-pulse at k+2 extends it
    bus.flash = 2'b01;
    cyc(1);                                   // after k
    bus.flash = 2'b00;
    chk("fl_k", bus.color_out, PAL0);
    cyc(1);                                   // after k+1
    chk("fl_k1", bus.color_out, FL_P0);
    bus.flash = 2'b01;
    cyc(1);                                   // after k+2
    bus.flash = 2'b00;
    chk("fl_k2", bus.color_out, FL_P0);
    cyc(2);                                   // after k+4
    chk("fl_k4", bus.color_out, FL_P0);
    cyc(1);                                   // after k+5
    chk("fl_k5_ext", bus.color_out, FL_P0);
    cyc(1);                                   // after k+6
    chk("fl_k6", bus.color_out, FL_P0);
    cyc(1);                                   // after k+7
    chk("fl_end", bus.color_out, PAL0);
    cyc(2);
    chk("fl_idle", bus.color_out, PAL0);

    // Flash player 1, then reset mid-flash
    bus.flash = 2'b10;
    cyc(1);
    bus.flash = 2'b00;
    cyc(1);
    chk("fl1_on", bus.color_out, FL_P1);
    #2;
    reset = 1'b1;
    #1;
    chk("fl1_rst", bus.color_out, PAL0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("fl1_after_rst", bus.color_out, PAL0);
    cyc(1);
    chk("fl1_after_rst2", bus.color_out, PAL0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palette_sequencer.md
# palette_sequencer

Parametrised player-colour generator for the VGA game datapath. It holds a palette index, and advances it on a debounced-clean button edge or on an automatic timer. It maps each player to a 24-bit RGB colour from a fixed base table and can flash any player to a highlight colour for a programmable time. It feeds the pixel renderer directly: one registered colour per player, valid from reset onward.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of player colour channels (1..8)
- NUM_PALETTES, 4, palette count, index wraps modulo this (2..8)
- PLAYER_STRIDE, 2, base-table offset between consecutive players
- AUTO_PERIOD, 25_000_000, clock cycles between automatic advances (≥2)
- FLASH_LEN, 12_500_000, cycles a flash lasts (≥1)
- FLASH_COLOR, 24'hFFFFFF, colour shown while flashing

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  asynchronous, active-high reset
- toggle_color  in  1  asynchronous level from button; each rising edge advances the palette by +1
- step_back  in  1  asynchronous level from button; each rising edge steps the palette by −1
- auto_en  in  1  synchronous; 1 = timer advances the palette every AUTO_PERIOD cycles
- flash  in  NUM_PLAYERS  synchronous one-cycle pulses; bit i starts or restarts the flash of player i
- color_out  out  NUM_PLAYERS*24  player i colour at bits [24*i+23 : 24*i], registered
- palette_idx  out  clog2(NUM_PALETTES) (min 1)  current palette index, registered
- wrap  out  1  one-cycle pulse when the index wraps in either direction

## Operation
- Colour of player i in palette p is BASE[(p + i*PLAYER_STRIDE) mod 8].
- The BASE table is: 0 FF0000, 1 00FF00, 2 0000FF, 3 FFFF00, 4 00FFFF, 5 FF00FF, 6 FF8000, 7 FFFFFF.
- toggle_color and step_back each pass through a 2-FF synchroniser and a rising-edge detector. Holding a button high produces exactly one step.
- Step resolution, per cycle:
  - Forward and back edges in the same cycle: no change, counted as no step.
  - Forward edge or auto tick, or both together: one +1 step. Never +2.
  - Forward: NUM_PALETTES−1 → 0 asserts wrap.
  - Back: 0 → NUM_PALETTES−1 asserts wrap.
- Auto timer:
  - Counts 0..AUTO_PERIOD−1 while auto_en=1.
  - Issues a tick when it reaches AUTO_PERIOD−1, then returns to 0.
  - Is held at 0 while auto_en=0.
  - Any button-caused step also clears it to 0.
- Flash, per player:
  - flash[i]=1 loads flash_cnt[i] with FLASH_LEN.
  - The counter decrements to 0 and saturates there.
  - A new pulse while the counter is non-zero reloads it to FLASH_LEN.
  - While flash_cnt[i] ≠ 0, player i shows FLASH_COLOR. Otherwise it shows its palette colour.
  - Palette changes during a flash are applied internally and appear when the flash ends.
- Reset values:
  - palette_idx = 0, wrap = 0.
  - color_out = palette-0 colours (defaults: player 0 FF0000, player 1 0000FF).
  - All counters, synchroniser and edge flops are 0.
- Reset asserted mid-flash or mid-count aborts it immediately.

## Timing
- Button path:
  - Input high before edge k: synchroniser captures at k, second flop at k+1.
  - palette_idx and wrap update at edge k+2.
  - color_out reflects the new index at edge k+3.
- Auto path: tick decoded at count AUTO_PERIOD−1. palette_idx updates on that edge; color_out one edge later.
- Flash path:
  - flash[i] sampled at edge k sets flash_cnt[i] = FLASH_LEN at k.
  - color_out[i] = FLASH_COLOR at edges k+1 .. k+FLASH_LEN.
  - Palette colour returns at edge k+FLASH_LEN+1.
- wrap is high for exactly the cycle following the wrapping update edge. It is registered alongside palette_idx.

## Structure
- Package color_pkg:
  - COLOR_W = 24 and the 8-entry BASE table.
  - Function base_color(p, i, stride).
- Sub-module btn_sync_edge (2-FF synchroniser plus rising-edge pulse), instantiated once each for toggle_color and step_back.
- Top contains:
  - index/wrap logic;
  - auto timer;
  - generate loop of NUM_PLAYERS flash counters;
  - registered colour mux.

## Test plan
All scenarios use NUM_PLAYERS=2, NUM_PALETTES=4, PLAYER_STRIDE=2, AUTO_PERIOD=8, FLASH_LEN=4.
- Reset: color_out = {0000FF, FF0000} (player 1, player 0) and palette_idx=0 during and after reset.
- Held toggle_color: hold high 20 cycles → exactly one step, idx=1, color_out = {FFFF00, 00FF00}, arriving at the k+2 / k+3 edges.
- Forward wrap: 4 separated toggle_color edges → idx 1,2,3,0, one wrap pulse on 3→0. step_back from 0 → idx=3 plus a wrap pulse.
- Simultaneous edges: toggle_color and step_back rise together → idx unchanged, no wrap.
- Auto and collision: auto_en=1 → idx increments every 8 cycles. A button edge coincident with a tick gives a +1 step only, and the timer restarts.
- Flash: flash=2'b01 → player 0 = FFFFFF for 4 cycles. Re-pulse at cycle 2 → 4 more cycles from that point. Player 1 is unaffected. Reset mid-flash → palette-0 colour immediately.
